// File: rtl/fifo_drain_framer_if.sv
// Read port of the upstream FIFO plus the framed valid/ready stream, bundled
// so the framer and its environment connect through one port.
interface fifo_drain_framer_if #(
  parameter int BUS_WIDTH = 8
);
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [BUS_WIDTH-1:0] fifo_bus_out;
  logic                 fifo_valid;
  logic [BUS_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_sof;
  logic                 m_eof;

  modport master (
    input  fifo_empty, fifo_bus_out, fifo_valid, m_ready,
    output fifo_rd_en, m_data, m_valid, m_sof, m_eof
  );

  modport slave (
    output fifo_empty, fifo_bus_out, fifo_valid, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_sof, m_eof
  );
endinterface

// File: rtl/fifo_drain_framer.sv
// Drains a 1-cycle-latency FIFO into a small prefetch buffer and emits
// header / FRAME_LEN payload / XOR-checksum trailer frames on a valid/ready port.
module fifo_drain_framer #(
  parameter int BUS_WIDTH      = 8,
  parameter int FRAME_LEN      = 4,
  parameter int PREFETCH_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_drain_framer_if.master   bus,
  output logic [15:0]           frame_count
);
  localparam int PTR_W  = $clog2(PREFETCH_DEPTH);
  localparam int CNT_W  = $clog2(PREFETCH_DEPTH + 1);
  localparam int BEAT_W = $clog2(FRAME_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  // states: IDLE wait for payload | HEADER seq word | PAYLOAD buffered words | TRAILER checksum
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

  state_t               state;
  logic [BUS_WIDTH-1:0] buf_mem [PREFETCH_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_ptr_next;
  logic [CNT_W-1:0]     buf_count, buf_count_next, remaining;
  logic [CNT_W:0]       occupancy;
  logic                 inflight;
  logic                 push, pop, beat;
  logic                 buf_nonempty, next_nonempty;
  logic [BUS_WIDTH-1:0] head_next;
  logic [BUS_WIDTH-1:0] seq, checksum;
  logic [BEAT_W-1:0]    beat_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(PREFETCH_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Requests in flight count against capacity, so the buffer can never overflow.
  assign occupancy      = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight};
  assign bus.fifo_rd_en = !bus.fifo_empty && !rst &&
                          (occupancy < (CNT_W+1)'(PREFETCH_DEPTH));
  assign push           = bus.fifo_valid && inflight;
  assign beat           = bus.m_valid && bus.m_ready;
  assign pop            = (state == PAYLOAD) && beat;
  assign buf_nonempty   = (buf_count != '0);

  always_comb begin
    buf_count_next = buf_count;
    case ({push, pop})
      2'b10:   buf_count_next = buf_count + CNT_W'(1);
      2'b01:   buf_count_next = buf_count - CNT_W'(1);
      default: buf_count_next = buf_count;
    endcase
  end

  // Head after this edge: an older entry if one survives the pop, else the word being pushed.
  assign rd_ptr_next   = pop ? ptr_inc(rd_ptr) : rd_ptr;
  assign remaining     = buf_count - {{(CNT_W-1){1'b0}}, pop};
  assign next_nonempty = (buf_count_next != '0);
  assign head_next     = (remaining != '0) ? buf_mem[rd_ptr_next] : bus.fifo_bus_out;

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= bus.fifo_bus_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      buf_count <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight  <= bus.fifo_rd_en;
      buf_count <= buf_count_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      seq         <= '0;
      checksum    <= '0;
      beat_cnt    <= '0;
      frame_count <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_sof   <= 1'b0;
      bus.m_eof   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (buf_nonempty) begin
            state       <= HEADER;
            bus.m_valid <= 1'b1;
            bus.m_sof   <= 1'b1;
            bus.m_data  <= seq;
          end
        end
        HEADER: begin
          if (beat) begin
            state       <= PAYLOAD;
            checksum    <= '0;
            beat_cnt    <= '0;
            bus.m_sof   <= 1'b0;
            bus.m_valid <= next_nonempty;
            bus.m_data  <= next_nonempty ? head_next : '0;
          end
        end
        PAYLOAD: begin
          if (beat && beat_cnt == LAST_BEAT) begin
            state       <= TRAILER;
            checksum    <= checksum ^ bus.m_data;
            beat_cnt    <= beat_cnt + 1'b1;
            bus.m_valid <= 1'b1;
            bus.m_eof   <= 1'b1;
            bus.m_data  <= checksum ^ bus.m_data;
          end else begin
            if (beat) begin
              checksum <= checksum ^ bus.m_data;
              beat_cnt <= beat_cnt + 1'b1;
            end
            bus.m_valid <= next_nonempty;
            bus.m_data  <= next_nonempty ? head_next : '0;
          end
        end
        TRAILER: begin
          if (beat) begin
            seq         <= seq + 1'b1;
            frame_count <= frame_count + 16'd1;
            bus.m_eof   <= 1'b0;
            if (next_nonempty) begin
              state       <= HEADER;
              bus.m_valid <= 1'b1;
              bus.m_sof   <= 1'b1;
              bus.m_data  <= seq + 1'b1;
            end else begin
              state       <= IDLE;
              bus.m_valid <= 1'b0;
              bus.m_data  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_drain_framer.sv
// Directed bench for fifo_drain_framer: behavioural FIFO, beat monitor,
// table of single frames plus hand sequences for back-to-back, stall, reset, wrap.
module tb_fifo_drain_framer;
  logic        clk = 1'b1;
  logic        rst;
  logic [15:0] frame_count;

  fifo_drain_framer_if #(.BUS_WIDTH(8)) bus ();

  fifo_drain_framer #(.BUS_WIDTH(8), .FRAME_LEN(4), .PREFETCH_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    int         cyc;
  } beat_t;

  typedef struct {
    logic [3:0][7:0] w;
    logic [7:0]      hdr;
    logic [7:0]      csum;
  } vec_t;

  beat_t      beats [$];
  int         cyc       = 0;
  int         rd_pulses = 0;
  logic [7:0] words [$];
  int         rd_idx     = 0;
  int         flush_idx  = 0;
  int         stale_req  = 0;
  int         stale_seen = 0;
  logic       rd_seen    = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         bi    = 0;
  int         rd_base = 0;
  vec_t       vecs [5];

  // Monitor: counts read requests and records every transferred beat.
  always @(posedge clk) begin
    cyc = cyc + 1;
    rd_seen = bus.fifo_rd_en;
    if (bus.fifo_rd_en) rd_pulses = rd_pulses + 1;
    if (bus.m_valid && bus.m_ready)
      beats.push_back('{data: bus.m_data, sof: bus.m_sof, eof: bus.m_eof, cyc: cyc});
  end

  // FIFO model: a request seen at a posedge returns data (valid) in the following cycle.
  always @(negedge clk) begin
    if (rd_idx < flush_idx) rd_idx = flush_idx;
    bus.fifo_valid = 1'b0;
    if (rd_seen && rd_idx < words.size()) begin
      bus.fifo_bus_out = words[rd_idx];
      bus.fifo_valid   = 1'b1;
      rd_idx = rd_idx + 1;
    end else if (stale_req != stale_seen) begin
      bus.fifo_bus_out = 8'hEE;
      bus.fifo_valid   = 1'b1;
      stale_seen = stale_req;
    end
    bus.fifo_empty = (rd_idx >= words.size());
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [3:0][7:0] mk(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic push4(input logic [3:0][7:0] w);
    for (int j = 0; j < 4; j++) words.push_back(w[j]);
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int k = 0;
    while ((beats.size() - bi) < n && k < budget) begin
      step();
      k++;
    end
    check(name, 32'((beats.size() - bi) >= n), 1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] hdr,
                             input logic [3:0][7:0] w, input logic [7:0] csum);
    logic [7:0] exp_d;
    if ((beats.size() - bi) < 6) return;
    for (int j = 0; j < 6; j++) begin
      if (j == 0)      exp_d = hdr;
      else if (j == 5) exp_d = csum;
      else             exp_d = w[j-1];
      check($sformatf("%s_data%0d", tag, j), beats[bi+j].data, exp_d);
      check($sformatf("%s_sof%0d", tag, j), beats[bi+j].sof, 32'(j == 0));
      check($sformatf("%s_eof%0d", tag, j), beats[bi+j].eof, 32'(j == 5));
    end
    bi += 6;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_idx = words.size();
    step(2);
    rst = 1'b0;
    bi = beats.size();
    rd_base = rd_pulses;
  endtask

  initial begin
    int k;
    vecs[0] = '{w: mk(8'h11, 8'h22, 8'h33, 8'h44), hdr: 8'h00, csum: 8'h44};
    vecs[1] = '{w: mk(8'h01, 8'h02, 8'h03, 8'h04), hdr: 8'h01, csum: 8'h04};
    vecs[2] = '{w: mk(8'h05, 8'h06, 8'h07, 8'h08), hdr: 8'h02, csum: 8'h0C};
    vecs[3] = '{w: mk(8'hA5, 8'h5A, 8'hFF, 8'h00), hdr: 8'h03, csum: 8'h00};
    vecs[4] = '{w: mk(8'h80, 8'h40, 8'h20, 8'h11), hdr: 8'h04, csum: 8'hF1};

    rst = 1'b1;
    bus.m_ready = 1'b0;
    step(3);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_sof", bus.m_sof, 0);
    check("rst_m_eof", bus.m_eof, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_frame_count", frame_count, 0);
    rst = 1'b0;
    bi = beats.size();
    rd_base = rd_pulses;

    // Single frames, one at a time, from the table.
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push4(vecs[i].w);
      wait_beats($sformatf("vec%0d_beats", i), 6, 60);
      check_frame($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].w, vecs[i].csum);
      step(3);
      check($sformatf("vec%0d_frame_count", i), frame_count, 32'(i + 1));
      check($sformatf("vec%0d_rd_pulses", i), 32'(rd_pulses - rd_base), 32'(4 * (i + 1)));
      check($sformatf("vec%0d_idle", i), bus.m_valid, 0);
    end

    // Back-to-back frames: no idle cycle between trailer and next header.
    do_reset();
    bus.m_ready = 1'b1;
    push4(mk(8'h01, 8'h02, 8'h03, 8'h04));
    push4(mk(8'h05, 8'h06, 8'h07, 8'h08));
    wait_beats("b2b_beats", 12, 100);
    check_frame("b2b_f1", 8'h00, mk(8'h01, 8'h02, 8'h03, 8'h04), 8'h04);
    if (beats.size() > bi && bi > 0)
      check("b2b_gap", 32'(beats[bi].cyc - beats[bi-1].cyc), 1);
    check_frame("b2b_f2", 8'h01, mk(8'h05, 8'h06, 8'h07, 8'h08), 8'h0C);
    step(3);
    check("b2b_frame_count", frame_count, 2);

    // Backpressure: header held stable, prefetch limited to buffer depth.
    bus.m_ready = 1'b0;
    do_reset();
    push4(mk(8'hC1, 8'hC2, 8'hC3, 8'hC4));
    push4(mk(8'hC5, 8'hC6, 8'hC7, 8'hC8));
    step(4);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid%0d", i), bus.m_valid, 1);
      check($sformatf("bp_sof%0d", i), bus.m_sof, 1);
      check($sformatf("bp_data%0d", i), bus.m_data, 0);
      step();
    end
    check("bp_rd_pulses", 32'(rd_pulses - rd_base), 2);
    bus.m_ready = 1'b1;
    wait_beats("bp_beats", 12, 100);
    check_frame("bp_f1", 8'h00, mk(8'hC1, 8'hC2, 8'hC3, 8'hC4), 8'h04);
    check_frame("bp_f2", 8'h01, mk(8'hC5, 8'hC6, 8'hC7, 8'hC8), 8'h0C);

    // FIFO runs dry mid-frame, then resumes.
    do_reset();
    bus.m_ready = 1'b1;
    words.push_back(8'h11);
    words.push_back(8'h22);
    step(20);
    check("dry_beats", 32'(beats.size() - bi), 3);
    check("dry_m_valid", bus.m_valid, 0);
    check("dry_m_eof", bus.m_eof, 0);
    check("dry_frame_count", frame_count, 0);
    words.push_back(8'h33);
    words.push_back(8'h44);
    wait_beats("dry_resume_beats", 6, 50);
    check_frame("dry", 8'h00, mk(8'h11, 8'h22, 8'h33, 8'h44), 8'h44);
    step(2);
    check("dry_frame_count_done", frame_count, 1);

    // Asynchronous reset during payload beat 2, stale fifo_valid afterwards.
    do_reset();
    bus.m_ready = 1'b1;
    push4(mk(8'h11, 8'h22, 8'h33, 8'h44));
    k = 0;
    while (!(bus.m_valid && bus.m_data == 8'h22) && k < 30) begin
      step();
      k++;
    end
    check("ar_reach_beat2", 32'(bus.m_valid && bus.m_data == 8'h22), 1);
    rst = 1'b1;
    flush_idx = words.size();
    #1;
    check("ar_m_valid", bus.m_valid, 0);
    check("ar_m_data", bus.m_data, 0);
    check("ar_m_sof", bus.m_sof, 0);
    check("ar_m_eof", bus.m_eof, 0);
    check("ar_rd_en", bus.fifo_rd_en, 0);
    check("ar_frame_count", frame_count, 0);
    step(2);
    rst = 1'b0;
    stale_req++;
    bi = beats.size();
    step(4);
    check("stale_no_beats", 32'(beats.size() - bi), 0);
    check("stale_m_valid", bus.m_valid, 0);
    check("stale_frame_count", frame_count, 0);
    push4(mk(8'h55, 8'h66, 8'h77, 8'h88));
    wait_beats("ar_after_beats", 6, 60);
    check_frame("ar_after", 8'h00, mk(8'h55, 8'h66, 8'h77, 8'h88), 8'hCC);

    // 256 frames: header sequence wraps back to 0x00.
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 1024; i++) words.push_back(i[7:0]);
    k = 0;
    while (frame_count != 16'd256 && k < 6000) begin
      step();
      k++;
    end
    check("wrap_frame_count", frame_count, 256);
    step(3);
    bi = beats.size();
    push4(mk(8'hA1, 8'hA2, 8'hA3, 8'hA4));
    wait_beats("wrap_hdr_beats", 1, 30);
    if (beats.size() > bi) begin
      check("wrap_hdr_data", beats[bi].data, 0);
      check("wrap_hdr_sof", beats[bi].sof, 1);
    end
    check("wrap_frame_count_hold", frame_count, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_drain_framer.md
Name: fifo_drain_framer

Overview:
- Sits directly downstream of the synchronous FIFO buffer and drains it through the FIFO's rd_en / bus_out / valid read port.
- Packs the drained words into fixed-length frames of one header word, FRAME_LEN payload words and one XOR-checksum trailer word.
- Presents each frame on a valid/ready streaming master port to the next stage.
- Absorbs the FIFO's 1-cycle read latency and downstream backpressure with a small internal prefetch buffer.

Parameters:
- BUS_WIDTH, 8: width of FIFO words and of m_data.
- FRAME_LEN, 4: payload words per frame; must be >= 1.
- PREFETCH_DEPTH, 2: entries in the internal payload prefetch buffer; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  read request to FIFO.
- fifo_bus_out  in  BUS_WIDTH  FIFO read data, valid when fifo_valid = 1.
- fifo_valid  in  1  FIFO read-data qualifier; asserted the cycle after an accepted rd_en.
- m_data  out  BUS_WIDTH  frame word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the word; a beat transfers when m_valid & m_ready.
- m_sof  out  1  current word is the header.
- m_eof  out  1  current word is the trailer.
- frame_count  out  16  frames completed since reset; wraps at 2^16.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: fifo_rd_en=0, m_valid=0, m_data=0, m_sof=0, m_eof=0, frame_count=0. Also state=IDLE, seq=0, checksum=0, beat counter=0, prefetch buffer empty, inflight=0.
- Prefetch, fifo_rd_en:
  - fifo_rd_en is combinational: fifo_rd_en = !fifo_empty & !rst & (buf_count + inflight < PREFETCH_DEPTH).
  - inflight is a 1-bit register: set on a cycle with fifo_rd_en=1, cleared otherwise.
  - A cycle with fifo_valid=1 and inflight=1 pushes fifo_bus_out into the buffer.
  - fifo_valid with inflight=0 is ignored, i.e. stale data after reset is dropped.
  - The buffer can never overflow. Push and pop in the same cycle are legal.
- Prefetch runs independently of the frame FSM.
- FSM states: IDLE, HEADER, PAYLOAD, TRAILER.
  - IDLE: m_valid=0. Go to HEADER when buf_count > 0, so a frame only starts when payload is available.
  - HEADER: m_valid=1, m_sof=1, m_data = seq (BUS_WIDTH bits). On the beat, clear checksum and beat counter, then go to PAYLOAD.
  - PAYLOAD: m_valid = (buf_count > 0), m_data = buffer head. On each beat: pop, checksum ^= head, beat counter++. After FRAME_LEN beats go to TRAILER. m_valid may drop between payload words when the buffer runs dry; this is legal.
  - TRAILER: m_valid=1, m_eof=1, m_data = checksum. On the beat: seq++ (wraps mod 2^BUS_WIDTH), frame_count++, then go to IDLE, or straight to HEADER if buf_count > 0 after any pop.
- Output rules:
  - m_data, m_valid, m_sof and m_eof derive only from registered state and the buffer head. There is no combinational path from m_ready to them.
  - Once m_valid=1, m_data, m_sof and m_eof stay stable until the beat transfers.
  - m_sof and m_eof are 0 whenever m_valid=0.
- Back-to-back frames: a header may follow a trailer with zero idle cycles.
- Reset mid-frame: the partial frame is abandoned with no trailer, and all state returns to reset values immediately (asynchronous).
- FIFO going empty mid-frame: the frame stalls in PAYLOAD until data arrives; no timeout.

Test Plan (BUS_WIDTH=8, FRAME_LEN=4):
1. FIFO holds 0x11,0x22,0x33,0x44; m_ready=1 -> beats 0x00(sof), 0x11, 0x22, 0x33, 0x44, 0x44(eof); frame_count=1; fifo_rd_en asserted exactly 4 times.
2. FIFO holds 8 words 0x01..0x08, m_ready=1 -> frames back-to-back, no idle cycle between eof and sof. Second header=0x01, second trailer=0x05^0x06^0x07^0x08=0x0C; frame_count=2.
3. m_ready=0 for 10 cycles with FIFO full -> no more than 2 fifo_rd_en pulses; m_data/m_valid/m_sof stable throughout; on release, data order is unchanged.
4. Only 2 words in FIFO mid-frame -> m_valid falls after payload beat 2 with the FSM held in PAYLOAD. Writing 0x33,0x44 resumes the frame with correct checksum and m_eof.
5. Assert rst during payload beat 2 -> outputs zero in the same cycle. After release: frame_count=0, next header=0x00, and a stale fifo_valid one cycle after reset is ignored.
6. Run 256 frames -> header of frame 257 = 0x00; frame_count=256.
